// File: rtl/cover_toggle_sched_if.sv
// cover_toggle_sched_if
//   Report-port bundle between the toggle-cover scheduler and the shared
//   cover reporter. One beat moves when out_valid & out_ready are both high.
// Signals
//   out_valid  scheduler -> reporter  beat valid, held until accepted
//   out_ready  reporter  -> scheduler reporter can take the beat this cycle
//   out_index  scheduler -> reporter  64-bit global cover index of the beat
// Modports
//   master : scheduler side (drives out_valid/out_index)
//   slave  : reporter side (drives out_ready)
interface cover_toggle_sched_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;

  modport master (
    output out_valid,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched
//   Collects per-bit toggle-cover hits from one coverage group and serialises
//   them onto a single report port, one global cover index per accepted beat.
//   Repeated hits on a bit coalesce while it is pending; with DEDUP=1 a bit is
//   reported at most once until clear.
// Parameters
//   WIDTH       cover points in this group (1..64)
//   COVER_INDEX global index of bit 0
//   COVER_TOTAL total cover points in the design (simulation bounds check)
//   DEDUP       1: report each bit once until clear, 0: report every hit
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   enable       in   1 = accept hits; falling edge starts a drain
//   clear        in   pulse: drop pending hits, forget the reported set
//   valid        in   WIDTH per-bit hit strobes
//   rpt          if   report port (master side: out_valid/out_index/out_ready)
//   pending_cnt  out  pending hits plus the beat currently presented
//   all_hit      out  every bit reported since last clear (DEDUP=1 only)
//   drain_done   out  one-cycle pulse when a drain empties out
module cover_toggle_sched #(
  parameter int unsigned     WIDTH       = 36,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 10906,
  parameter bit              DEDUP       = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [WIDTH-1:0]    valid,
  cover_toggle_sched_if.master rpt,
  output logic [6:0]          pending_cnt,
  output logic                all_hit,
  output logic                drain_done
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   pending_d;
  logic [WIDTH-1:0]   reported;
  logic [WIDTH-1:0]   reported_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_d;

  logic [WIDTH-1:0]   upper_mask;
  logic [WIDTH-1:0]   masked;
  logic               hi_found;
  logic [PTR_W-1:0]   hi_bit;
  logic [PTR_W-1:0]   lo_bit;
  logic [PTR_W-1:0]   sel_bit;
  logic [WIDTH-1:0]   sel_onehot;
  logic               load;
  logic               capture;
  logic [WIDTH-1:0]   suppress;
  logic [6:0]         cnt_acc;

  // Round-robin pick: lowest pending bit at or above rr_ptr, otherwise wrap
  // around to the lowest pending bit overall.
  always_comb begin
    upper_mask = '0;
    hi_found   = 1'b0;
    hi_bit     = '0;
    lo_bit     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upper_mask[i] = (PTR_W'(i) >= rr_ptr);
    end
    masked = pending & upper_mask;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (masked[i]) begin
        hi_found = 1'b1;
        hi_bit   = PTR_W'(i);
      end
      if (pending[i]) begin
        lo_bit = PTR_W'(i);
      end
    end
    sel_bit    = hi_found ? hi_bit : lo_bit;
    sel_onehot = WIDTH'(1) << sel_bit;
  end

  // Next pending/reported/pointer. The reported mask used for suppression
  // already includes the bit being loaded this cycle, so with DEDUP=1 a
  // same-cycle re-hit is dropped while with DEDUP=0 it re-arms the bit.
  // A clear cycle neither captures nor loads; an in-flight beat is untouched.
  always_comb begin
    load       = (|pending) & (~rpt.out_valid | rpt.out_ready) & ~clear;
    capture    = (state_q == RUN) & ~clear;
    reported_d = reported | (load ? sel_onehot : '0);
    suppress   = DEDUP ? reported_d : '0;
    pending_d  = (pending & ~(load ? sel_onehot : '0))
               | (capture ? (valid & ~suppress) : '0);
    rr_ptr_d   = rr_ptr;
    if (load) begin
      rr_ptr_d = (sel_bit == PTR_W'(WIDTH - 1)) ? '0 : sel_bit + PTR_W'(1);
    end
    if (clear) begin
      pending_d  = '0;
      reported_d = '0;
      rr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      reported <= '0;
      rr_ptr   <= '0;
    end else begin
      pending  <= pending_d;
      reported <= reported_d;
      rr_ptr   <= rr_ptr_d;
    end
  end

  // Output register: a new beat replaces the current one only once it has
  // been accepted (or none is presented), so a beat is never withdrawn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt.out_valid <= 1'b0;
      rpt.out_index <= '0;
    end else if (load) begin
      rpt.out_valid <= 1'b1;
      rpt.out_index <= COVER_INDEX + 64'(sel_bit);
    end else if (rpt.out_ready) begin
      rpt.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // drain_done is raised only in the last DRAIN cycle, when nothing is
  // pending and no beat is presented; re-enabling mid-drain skips it.
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((pending == '0) && !rpt.out_valid) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_acc = {6'd0, rpt.out_valid};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_acc = cnt_acc + {6'd0, pending[i]};
    end
  end

  assign pending_cnt = cnt_acc;
  assign all_hit     = DEDUP & (&reported);

  // Simulation-only range check on every presented index.
  a_index_in_range : assert property (
    @(posedge clock) disable iff (!reset)
    rpt.out_valid |-> (rpt.out_index < COVER_TOTAL)
  );

endmodule
